// File: rtl/switch_allocator_aging_pkg.sv
// Shared router configuration: port counts, default starvation threshold, age counter sizing.
package switch_allocator_aging_pkg;

  localparam int N           = 5;
  localparam int M           = 5;
  localparam int AGE_MAX_DEF = 8;

  function automatic int age_width(input int age_max);
    return $clog2(age_max + 1);
  endfunction

  localparam int AGE_W = age_width(AGE_MAX_DEF);
  typedef logic [AGE_W-1:0] age_t;

endpackage

// File: rtl/switch_allocator_aging_output_rr_arbiter.sv
// Per-output round-robin arbiter; starved requesters pre-empt the normal pool.
// Grant is combinational, pointer advances past the winner on the next edge.
module output_rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         en,
  input  logic [0:N-1] req,
  input  logic [0:N-1] starved,
  output logic [0:N-1] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [0:N-1]  pool;
  logic          found;
  logic          fire;
  int            idx;

  always_comb begin
    pool  = (|(req & starved)) ? (req & starved) : req;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    // Walk from ptr upward, wrapping at N; first hit in the pool wins.
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && pool[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    fire  = found & en & ce & reset_n;
    grant = '0;
    if (fire) grant[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/switch_allocator_aging.sv
// Separable switch allocator: lowest-output request masking, per-output RR arbiters,
// and per-input age counters that force priority for inputs waiting AGE_MAX cycles.
module switch_allocator_aging
  import switch_allocator_aging_pkg::*;
#(
  parameter int AGE_MAX = AGE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [0:M-1]         i_en,
  input  logic [0:N-1][0:M-1]  i_output_req,
  output logic [0:M-1][0:N-1]  o_output_grant,
  output logic [0:N-1]         o_input_grant,
  output logic [0:N-1]         o_starved
);

  localparam int AW = age_width(AGE_MAX);
  localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

  logic [0:N-1][0:M-1] eff_req;
  logic [0:M-1][0:N-1] arb_req;
  logic [0:N-1][0:M-1] gnt_col;
  logic [0:N-1]        seen;
  logic [0:N-1]        starved;
  logic [0:N-1]        ig;
  logic [0:N-1]        arb_gnt [M];
  logic [AW-1:0]       age     [N];
  logic [AW-1:0]       age_nxt [N];

  // Keep only the lowest-index output per input so one input never wins twice.
  always_comb begin
    eff_req = '0;
    seen    = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (!seen[n] && i_output_req[n][m]) begin
          eff_req[n][m] = 1'b1;
          seen[n]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    arb_req = '0;
    starved = '0;
    for (int n = 0; n < N; n++) begin
      starved[n] = (age[n] == AGE_SAT);
      for (int m = 0; m < M; m++) arb_req[m][n] = eff_req[n][m];
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_arb
    output_rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .en      (i_en[m]),
      .req     (arb_req[m]),
      .starved (starved),
      .grant   (arb_gnt[m])
    );
  end

  always_comb begin
    o_output_grant = '0;
    gnt_col        = '0;
    ig             = '0;
    for (int m = 0; m < M; m++) begin
      o_output_grant[m] = arb_gnt[m];
      ig                = ig | arb_gnt[m];
      for (int n = 0; n < N; n++) gnt_col[n][m] = arb_gnt[m][n];
    end
  end

  assign o_input_grant = ig;

  // Waiting (even behind a blocked output) ages; a grant or an idle input clears.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      age_nxt[n] = '0;
      if (!ig[n] && (|eff_req[n])) begin
        age_nxt[n] = (age[n] == AGE_SAT) ? age[n] : age[n] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < N; n++) age[n] <= '0;
      o_starved <= '0;
    end else if (ce) begin
      for (int n = 0; n < N; n++) begin
        age[n]       <= age_nxt[n];
        o_starved[n] <= (age_nxt[n] == AGE_SAT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int m = 0; m < M; m++) begin
        assert ($onehot0(o_output_grant[m]));
        for (int n = 0; n < N; n++) begin
          assert (!o_output_grant[m][n] || (i_output_req[n][m] && i_en[m]));
        end
      end
      for (int n = 0; n < N; n++) assert ($onehot0(gnt_col[n]));
    end
  end

endmodule

// File: tb/tb_switch_allocator_aging.sv
// Directed bench for switch_allocator_aging with AGE_MAX=4 and hand-derived grant sequences.
module tb_switch_allocator_aging;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ce;
  logic [0:4]      en;
  logic [0:4][0:4] req;
  logic [0:4][0:4] og;
  logic [0:4]      ig;
  logic [0:4]      st;

  int checks = 0;
  int errors = 0;

  switch_allocator_aging #(.AGE_MAX(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ce             (ce),
    .i_en           (en),
    .i_output_req   (req),
    .o_output_grant (og),
    .o_input_grant  (ig),
    .o_starved      (st)
  );

  always #5 clk = ~clk;

  function automatic logic [0:4] oh(input int n);
    logic [0:4] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Async reset between edges, then release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    ce      = 1'b1;
    en      = 5'b11111;
    #1;
    chk("reset_starved_clear", st, 5'b00000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    en      = 5'b11111;
    req     = '1;

    // Reset held with everything requesting: no grants at all.
    @(negedge clk); #1;
    chk("rst_output_grant", og, 0);
    chk("rst_input_grant", ig, 0);
    chk("rst_starved", st, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_first_og0", og[0], 5'b10000);
    chk("rel_first_ig", ig, 5'b10000);
    @(negedge clk); #1;
    chk("rel_second_og0", og[0], 5'b01000);

    // Five-way contention on output 2.
    do_reset();
    for (int n = 0; n < 5; n++) req[n][2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("rr_og2_c%0d", c), og[2], oh(c % 5));
      chk($sformatf("rr_ig_c%0d", c), ig, oh(c % 5));
      chk($sformatf("rr_st_c%0d", c), st, (c >= 4) ? oh(c % 5) : 5'b00000);
      @(negedge clk);
    end

    // Input 1 asks for outputs 1 and 3; only output 1 is considered.
    do_reset();
    req[1][1] = 1'b1;
    req[1][3] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("mask_og1_c%0d", c), og[1], 5'b01000);
      chk($sformatf("mask_og3_c%0d", c), og[3], 5'b00000);
      chk($sformatf("mask_ig_c%0d", c), ig, 5'b01000);
      @(negedge clk);
    end

    // Output 4 blocked: input 3 ages to the threshold.
    do_reset();
    en        = 5'b11110;
    req[3][4] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("blk_og_c%0d", c), og, 0);
      chk($sformatf("blk_st_c%0d", c), st, (c >= 4) ? 5'b00010 : 5'b00000);
      @(negedge clk);
    end
    en = 5'b11111;
    for (int n = 0; n < 5; n++) req[n][4] = 1'b1;
    #1;
    chk("age_override_og4", og[4], 5'b00010);
    chk("age_override_st", st, 5'b00010);
    @(negedge clk); #1;
    chk("age_after_st", st, 5'b00000);
    chk("age_after_og4", og[4], 5'b00001);

    // Disjoint requests all win together.
    do_reset();
    req[0][4] = 1'b1;
    req[1][3] = 1'b1;
    req[2][2] = 1'b1;
    #1;
    chk("par_og4", og[4], 5'b10000);
    chk("par_og3", og[3], 5'b01000);
    chk("par_og2", og[2], 5'b00100);
    chk("par_ig", ig, 5'b11100);

    // Clock-enable freeze mid-contention on output 0.
    do_reset();
    for (int n = 0; n < 5; n++) req[n][0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("ce_pre_og0_c%0d", c), og[0], oh(c));
      @(negedge clk);
    end
    ce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ce_off_og_c%0d", c), og, 0);
      chk($sformatf("ce_off_ig_c%0d", c), ig, 0);
      chk($sformatf("ce_off_st_c%0d", c), st, 0);
      @(negedge clk);
    end
    ce = 1'b1;
    for (int c = 2; c < 6; c++) begin
      #1;
      chk($sformatf("ce_resume_og0_c%0d", c), og[0], oh(c % 5));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
